// File: rtl/piso_pkg.sv
// Shared types and sizing helpers for the parallel-in/serial-out serializer.
package piso_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   // Counter width able to hold 0..n-1, never narrower than one bit.
   function automatic int cnt_width(input int n);
      int w;
      w = $clog2(n);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/piso_bit_timer.sv
// Bit-period timer: tick marks the last clock cycle of each DIV-cycle bit period.
// Single cycle of latency from restart; counts only while run is high.
module piso_bit_timer
   import piso_pkg::*;
#(
   parameter int DIV = 1
) (
   input  logic clk,
   input  logic reset_n,
   input  logic run,
   input  logic restart,
   output logic tick
);

   localparam int            CW   = cnt_width(DIV);
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] div_cnt;

   assign tick = (div_cnt == LAST);

   // Wraps to zero on tick, so a gapless reload needs no explicit restart.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         div_cnt <= '0;
      end else if (restart) begin
         div_cnt <= '0;
      end else if (run) begin
         div_cnt <= tick ? '0 : div_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/piso_serializer.sv
// PISO front end: one-entry hold buffer feeding a shifter; first bit one cycle after load, WIDTH*DIV cycles per frame.
// din_ready drops while the hold buffer is full; back-to-back words stream with no idle bit.
module piso_serializer
   import piso_pkg::*;
#(
   parameter int WIDTH     = 4,
   parameter int DIV       = 1,
   parameter int MSB_FIRST = 1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   output logic             din_ready,
   output logic             sout,
   output logic             sout_en,
   output logic             busy,
   output logic             frame_done
);

   localparam int            BW       = cnt_width(WIDTH);
   localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

   state_t           state_q;
   state_t           state_d;
   logic [WIDTH-1:0] hold_q;
   logic             hold_v;
   logic [WIDTH-1:0] shreg_q;
   logic [WIDTH-1:0] shreg_adv;
   logic [BW-1:0]    bit_cnt;
   logic             tick;
   logic             load;
   logic             advance;
   logic             accept;
   logic             last_bit;
   logic             in_shift;

   assign in_shift  = (state_q == SHIFT);
   assign din_ready = ~hold_v;
   assign accept    = din_valid & din_ready;
   assign last_bit  = (bit_cnt == BIT_LAST);

   piso_bit_timer #(
      .DIV (DIV)
   ) u_bit_timer (
      .clk     (clk),
      .reset_n (reset_n),
      .run     (in_shift),
      .restart (load),
      .tick    (tick)
   );

   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      advance = 1'b0;
      case (state_q)
         IDLE: begin
            if (hold_v) begin
               load    = 1'b1;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            if (tick) begin
               if (!last_bit) begin
                  advance = 1'b1;
               end else if (hold_v) begin
                  load = 1'b1;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Accept and load never coincide: accept needs hold_v low, load needs it high.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hold_v <= 1'b0;
         hold_q <= '0;
      end else if (accept) begin
         hold_v <= 1'b1;
         hold_q <= din;
      end else if (load) begin
         hold_v <= 1'b0;
      end
   end

   assign shreg_adv = (MSB_FIRST != 0) ? {shreg_q[WIDTH-2:0], 1'b0}
                                       : {1'b0, shreg_q[WIDTH-1:1]};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         shreg_q <= '0;
         bit_cnt <= '0;
      end else if (load) begin
         shreg_q <= hold_q;
         bit_cnt <= '0;
      end else if (advance) begin
         shreg_q <= shreg_adv;
         bit_cnt <= bit_cnt + 1'b1;
      end
   end

   assign busy       = in_shift;
   assign sout_en    = tick & in_shift;
   assign frame_done = sout_en & last_bit;
   assign sout       = in_shift & ((MSB_FIRST != 0) ? shreg_q[WIDTH-1] : shreg_q[0]);

endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboarded bench for two serializer configurations: DIV=1 MSB-first (a_*) and DIV=3 LSB-first (b_*).
module tb_piso_serializer;

   typedef struct {
      logic b;
      logic last;
   } exp_t;

   logic       clk;
   logic       reset_n;
   logic [3:0] a_din, b_din;
   logic       a_valid, b_valid;
   logic       a_ready, b_ready;
   logic       a_sout, b_sout;
   logic       a_en, b_en;
   logic       a_busy, b_busy;
   logic       a_fd, b_fd;
   logic [3:0] a_sipo, b_sipo;

   exp_t qa[$];
   exp_t qb[$];
   int   compared;
   int   failed;

   piso_serializer #(.WIDTH(4), .DIV(1), .MSB_FIRST(1)) dut_a (
      .clk(clk), .reset_n(reset_n), .din(a_din), .din_valid(a_valid), .din_ready(a_ready),
      .sout(a_sout), .sout_en(a_en), .busy(a_busy), .frame_done(a_fd)
   );

   piso_serializer #(.WIDTH(4), .DIV(3), .MSB_FIRST(0)) dut_b (
      .clk(clk), .reset_n(reset_n), .din(b_din), .din_valid(b_valid), .din_ready(b_ready),
      .sout(b_sout), .sout_en(b_en), .busy(b_busy), .frame_done(b_fd)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Downstream 4-bit SIPO stages: MSB-first shifts in at the bottom, LSB-first at the top.
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         a_sipo <= 4'h0;
         b_sipo <= 4'h0;
      end else begin
         if (a_en) a_sipo <= {a_sipo[2:0], a_sout};
         if (b_en) b_sipo <= {b_sout, b_sipo[3:1]};
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitors: every busy cycle the serial bit must equal the head of the queue; pop on strobe.
   always @(negedge clk) begin
      if (reset_n) begin
         if (a_busy) begin
            compared++;
            if (qa.size() == 0) begin
               failed++;
               $display("FAIL a_unexpected_bit: sout=%0b with empty scoreboard at %0t", a_sout, $time);
            end else begin
               if (a_sout !== qa[0].b) begin
                  failed++;
                  $display("FAIL a_sout: got %0b expected %0b at %0t", a_sout, qa[0].b, $time);
               end
               if (a_en) begin
                  compared++;
                  if (a_fd !== qa[0].last) begin
                     failed++;
                     $display("FAIL a_frame_done: got %0b expected %0b at %0t", a_fd, qa[0].last, $time);
                  end
                  void'(qa.pop_front());
               end
            end
         end else begin
            compared++;
            if ({a_sout, a_en, a_fd} !== 3'b000) begin
               failed++;
               $display("FAIL a_idle_outputs: got %03b expected 000 at %0t", {a_sout, a_en, a_fd}, $time);
            end
         end
      end
   end

   always @(negedge clk) begin
      if (reset_n) begin
         if (b_busy) begin
            compared++;
            if (qb.size() == 0) begin
               failed++;
               $display("FAIL b_unexpected_bit: sout=%0b with empty scoreboard at %0t", b_sout, $time);
            end else begin
               if (b_sout !== qb[0].b) begin
                  failed++;
                  $display("FAIL b_sout: got %0b expected %0b at %0t", b_sout, qb[0].b, $time);
               end
               if (b_en) begin
                  compared++;
                  if (b_fd !== qb[0].last) begin
                     failed++;
                     $display("FAIL b_frame_done: got %0b expected %0b at %0t", b_fd, qb[0].last, $time);
                  end
                  void'(qb.pop_front());
               end
            end
         end else begin
            compared++;
            if ({b_sout, b_en, b_fd} !== 3'b000) begin
               failed++;
               $display("FAIL b_idle_outputs: got %03b expected 000 at %0t", {b_sout, b_en, b_fd}, $time);
            end
         end
      end
   end

   // Called at a negedge; returns at the negedge after the accepting edge.
   task automatic send(input bit sel, input logic [3:0] w, input bit keep, output int waited);
      exp_t e;
      waited = 0;
      if (sel) begin b_din = w; b_valid = 1'b1; end
      else     begin a_din = w; a_valid = 1'b1; end
      while (!(sel ? b_ready : a_ready) && waited < 200) begin
         @(negedge clk);
         waited++;
      end
      if (!(sel ? b_ready : a_ready)) begin
         compared++;
         failed++;
         $display("FAIL accept_timeout: din_ready stayed 0, required 1 within 200 cycles");
         a_valid = 1'b0;
         b_valid = 1'b0;
         return;
      end
      for (int k = 0; k < 4; k++) begin
         e.b    = sel ? w[k] : w[3-k];
         e.last = (k == 3);
         if (sel) qb.push_back(e);
         else     qa.push_back(e);
      end
      @(negedge clk);
      if (!keep) begin
         if (sel) b_valid = 1'b0;
         else     a_valid = 1'b0;
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_a_ready"}, a_ready, 1);
      chk({tag, "_a_outs"}, {a_sout, a_en, a_busy, a_fd}, 0);
      chk({tag, "_b_ready"}, b_ready, 1);
      chk({tag, "_b_outs"}, {b_sout, b_en, b_busy, b_fd}, 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

   initial begin
      int         w;
      int         cnt;
      logic [3:0] p;
      compared = 0;
      failed   = 0;
      reset_n  = 1'b0;
      a_valid  = 1'b0;
      b_valid  = 1'b0;
      a_din    = 4'h0;
      b_din    = 4'h0;

      repeat (3) @(negedge clk);
      chk_reset_outputs("reset");
      reset_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("idle_a_ready", a_ready, 1);
         chk("idle_a_busy", a_busy, 0);
         chk("idle_b_ready", b_ready, 1);
      end

      // Single word, full rate, MSB first.
      p = 4'b1011;
      send(1'b0, p, 1'b0, w);
      chk("single_busy_before_load", a_busy, 0);
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         chk("single_sout", a_sout, p[4-k]);
         chk("single_en", a_en, 1);
         chk("single_fd", a_fd, (k == 4));
      end
      @(negedge clk);
      chk("single_busy_after", a_busy, 0);
      chk("single_sipo", a_sipo, 4'b1011);

      // Divided rate, LSB first.
      p = 4'b0110;
      send(1'b1, p, 1'b0, w);
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         chk("div_en", b_en, (k % 3 == 0));
         chk("div_sout", b_sout, p[(k-1)/3]);
      end
      @(negedge clk);
      chk("div_busy_after", b_busy, 0);
      chk("div_sipo", b_sipo, 4'b0110);

      // Back-to-back with a third word under backpressure.
      send(1'b0, 4'hA, 1'b1, w);
      send(1'b0, 4'h5, 1'b1, w);
      chk("b2b_second_wait", w, 1);
      chk("b2b_ready_pending", a_ready, 0);
      chk("b2b_busy", a_busy, 1);
      send(1'b0, 4'h3, 1'b0, w);
      chk("bp_third_wait", w, 3);
      cnt = 0;
      while (a_busy && cnt < 50) begin
         cnt++;
         @(negedge clk);
      end
      chk("b2b_busy_run", cnt, 7);
      chk("b2b_sipo", a_sipo, 4'h3);

      // Reset in the middle of a frame.
      send(1'b0, 4'hF, 1'b0, w);
      @(negedge clk);
      @(negedge clk);
      #2 reset_n = 1'b0;
      #1 chk_reset_outputs("midreset");
      qa.delete();
      qb.delete();
      @(negedge clk);
      chk_reset_outputs("midreset_held");
      reset_n = 1'b1;
      @(negedge clk);
      send(1'b0, 4'h9, 1'b0, w);
      repeat (5) @(negedge clk);
      chk("post_reset_busy", a_busy, 0);
      chk("post_reset_sipo", a_sipo, 4'h9);

      repeat (4) @(negedge clk);
      chk("qa_drained", qa.size(), 0);
      chk("qb_drained", qb.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
      $finish;
   end

endmodule
